alu_issue_ctrl: RTL and testbench

- Multi-cycle control sequencer that sits on the initiator side of the 8-bit ALU.
- Fetches 9-bit instructions, decodes them, and drives the ALU command and operands from an internal 8x8 register file.
- Captures the ALU result for writeback, branch resolution, or load/store addressing.
- Connects to the instruction ROM (combinational read), the ALU (combinational), and data memory (req/ack handshake).

---
 rtl/alu_pkg.sv | 35 +++
 rtl/reg_file_8x8.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: instruction opcodes,
// sequencer states, the HALT encoding and instruction field positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_XOR = 3'b010,
        OP_BNE = 3'b011,
        OP_LS  = 3'b100,
        OP_RS  = 3'b101,
        OP_LW  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // All-ones word is HALT; it shares the SW opcode and must be checked first.
    localparam logic [8:0] INSTR_HALT = 9'h1FF;

    // Instruction layout: [8:6] op, [5:3] rd, [2:0] rs.
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 0;

endpackage

// File: rtl/reg_file_8x8.sv
// 8-entry general register file for the issue controller.
// Ports:
//   clk_i, reset_i        clock and synchronous active-high clear of all entries
//   raddr_a_i/rdata_a_o   asynchronous read port A
//   raddr_b_i/rdata_b_o   asynchronous read port B
//   r0_o                  direct tap of r[0] (store base / branch offset)
//   we_i/waddr_i/wdata_i  synchronous write port
module reg_file_8x8
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [2:0]        raddr_a_i,
    input  logic [2:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] r0_o,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [8];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign r0_o      = regs_q[0];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer in front of an external combinational 8-bit ALU.
// Fetches 9-bit instructions from a combinational ROM, drives the ALU from an
// 8x8 register file and handles writeback, BNE and LW/SW via a req/ack port.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   start_i / done_o            run start pulse / high from HALT until restart
//   imem_addr_o / imem_data_i   program counter / fetched instruction
//   alu_cmd_o, alu_a_o, alu_b_o ALU command and operands (zero outside EXEC)
//   alu_rslt_i                  ALU result
//   mem_req_o, mem_we_o         data-memory request and direction (1=store)
//   mem_addr_o, mem_wdata_o     registered address and store data
//   mem_rdata_i, mem_ack_i      load data and one-cycle completion
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              done_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [8:0]        imem_data_i,
    output logic [2:0]        alu_cmd_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_rslt_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [8:0]        instr_q, instr_d;
    logic              done_q, done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    op_e        op;
    logic [2:0] rd;
    logic [2:0] rs;

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] rf_r0;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    logic signed [DATA_W-1:0] r0_s;
    logic [PC_W-1:0]          br_off;
    logic [PC_W-1:0]          pc_inc;

    assign op = op_e'(instr_q[OP_MSB:OP_LSB]);
    assign rd = instr_q[RD_MSB:RD_LSB];
    assign rs = instr_q[RS_MSB:RS_LSB];

    // Signed size cast sign-extends r[0] to the pc width; pc wraps freely.
    assign r0_s   = rf_r0;
    assign br_off = PC_W'(r0_s);
    assign pc_inc = pc_q + PC_W'(1);

    reg_file_8x8 #(
        .DATA_W(DATA_W)
    ) u_rf (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .raddr_a_i(rd),
        .raddr_b_i(rs),
        .rdata_a_o(rf_a),
        .rdata_b_o(rf_b),
        .r0_o     (rf_r0),
        .we_i     (rf_we),
        .waddr_i  (rd),
        .wdata_i  (rf_wdata)
    );

    // ALU drive: SW addresses off r[0] while port A still carries r[rd] as data.
    always_comb begin
        alu_cmd_o = 3'b000;
        alu_a_o   = '0;
        alu_b_o   = '0;
        if (state_q == EXEC) begin
            alu_cmd_o = op;
            alu_a_o   = (op == OP_SW) ? rf_r0 : rf_a;
            alu_b_o   = rf_b;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        done_d      = done_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_rslt_i;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    pc_d    = '0;
                    done_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                instr_d = imem_data_i;
                if (imem_data_i == INSTR_HALT) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (op)
                    OP_BNE: begin
                        pc_d = alu_rslt_i[0] ? (pc_q + br_off) : pc_inc;
                    end
                    OP_LW: begin
                        mem_addr_d = alu_rslt_i;
                        mem_we_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        state_d    = MEM;
                    end
                    OP_SW: begin
                        mem_addr_d  = alu_rslt_i;
                        mem_wdata_d = rf_a;
                        mem_we_d    = 1'b1;
                        mem_req_d   = 1'b1;
                        state_d     = MEM;
                    end
                    default: begin
                        rf_we = 1'b1;
                        pc_d  = pc_inc;
                    end
                endcase
            end
            MEM: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                    if (op == OP_LW) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata_i;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign done_o      = done_q;
    assign imem_addr_o = pc_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a program table stepped one instruction
// at a time with hand-computed ALU operands, memory fields and next pc,
// followed by HALT/restart and reset-during-memory sequences.
module tb_alu_issue_ctrl;

    localparam int PC_W   = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              done;
    logic [PC_W-1:0]   imem_addr;
    logic [8:0]        imem_data;
    logic [2:0]        alu_cmd;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_rslt;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .PC_W  (PC_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .done_o     (done),
        .imem_addr_o(imem_addr),
        .imem_data_i(imem_data),
        .alu_cmd_o  (alu_cmd),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_rslt_i (alu_rslt),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ack_i  (mem_ack)
    );

    // Reference ALU: LW/SW address = a + b, BNE reports inequality in bit 0.
    always_comb begin
        case (alu_cmd)
            3'd0:                alu_rslt = alu_a & alu_b;
            3'd1, 3'd6, 3'd7:    alu_rslt = alu_a + alu_b;
            3'd2:                alu_rslt = alu_a ^ alu_b;
            3'd3:                alu_rslt = {7'b0, (alu_a != alu_b)};
            3'd4:                alu_rslt = alu_a << alu_b;
            3'd5:                alu_rslt = alu_a >> alu_b;
            default:             alu_rslt = '0;
        endcase
    end

    typedef struct {
        logic [8:0] instr;
        logic [2:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic       is_mem;
        logic       we;
        logic [7:0] maddr;
        logic [7:0] mwdata;
        logic [7:0] rdata;
        int         wait_n;
        logic [7:0] pc_next;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [8:0] instr, input logic [2:0] cmd,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic is_mem, input logic we,
                                input logic [7:0] maddr, input logic [7:0] mwdata,
                                input logic [7:0] rdata, input int wait_n,
                                input logic [7:0] pc_next);
        vec_t v;
        v.instr = instr; v.cmd = cmd; v.a = a; v.b = b;
        v.is_mem = is_mem; v.we = we; v.maddr = maddr; v.mwdata = mwdata;
        v.rdata = rdata; v.wait_n = wait_n; v.pc_next = pc_next;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur_pc;

        //              instr           cmd   a      b      mem   we    maddr  wdata  rdata  wt  pc_next
        vecs[0]  = mk(9'b110_001_001, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h05, 0, 8'd1);   // LW r1 <- 5
        vecs[1]  = mk(9'b110_010_010, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h03, 0, 8'd2);   // LW r2 <- 3
        vecs[2]  = mk(9'b001_001_010, 3'd1, 8'h05, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd3);   // ADD r1=8
        vecs[3]  = mk(9'b010_001_010, 3'd2, 8'h08, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd4);   // XOR r1=0B
        vecs[4]  = mk(9'b000_001_010, 3'd0, 8'h0B, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd5);   // AND r1=03
        vecs[5]  = mk(9'b100_010_010, 3'd4, 8'h03, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd6);   // LS r2=18
        vecs[6]  = mk(9'b101_010_001, 3'd5, 8'h18, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd7);   // RS r2=03
        vecs[7]  = mk(9'b110_000_000, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h04, 0, 8'd8);   // LW r0 <- 4
        vecs[8]  = mk(9'b110_100_100, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h06, 0, 8'd9);   // LW r4 <- 6
        vecs[9]  = mk(9'b110_011_011, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 0, 8'd10);  // LW r3 <- A5
        vecs[10] = mk(9'b111_011_100, 3'd7, 8'h04, 8'h06, 1'b1, 1'b1, 8'h0A, 8'hA5, 8'h00, 4, 8'd11);  // SW r3,r4
        vecs[11] = mk(9'b110_101_101, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h02, 0, 8'd12);  // LW r5 <- 2
        vecs[12] = mk(9'b110_110_110, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 0, 8'd13);  // LW r6 <- 1
        vecs[13] = mk(9'b110_101_110, 3'd6, 8'h02, 8'h01, 1'b1, 1'b0, 8'h03, 8'h00, 8'h3C, 1, 8'd14);  // LW r5,r6
        vecs[14] = mk(9'b001_101_111, 3'd1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd15);  // r5 is 3C
        vecs[15] = mk(9'b110_000_111, 3'd6, 8'h04, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, 8'hFE, 0, 8'd16);  // LW r0 <- FE
        vecs[16] = mk(9'b011_001_010, 3'd3, 8'h03, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd17);  // BNE equal
        vecs[17] = mk(9'b001_001_110, 3'd1, 8'h03, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd18);  // ADD r1=4
        vecs[18] = mk(9'b011_001_010, 3'd3, 8'h04, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd16);  // BNE -2
        vecs[19] = mk(9'b010_001_001, 3'd2, 8'h04, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd17);  // XOR r1=0
        vecs[20] = mk(9'b011_001_111, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd18);  // BNE equal
        vecs[21] = mk(9'b110_000_111, 3'd6, 8'hFE, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h00, 8'hEC, 0, 8'd19);  // LW r0 <- EC
        vecs[22] = mk(9'b011_101_111, 3'd3, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd255); // BNE 19-20
        vecs[23] = mk(9'b001_111_111, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd0);   // pc wraps
        vecs[24] = mk(9'b001_111_111, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'd1);

        reset     = 1'b1;
        start     = 1'b0;
        imem_data = 9'h000;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        tick();
        tick();
        check("reset_done",   32'(done),      32'h0);
        check("reset_pc",     32'(imem_addr), 32'h0);
        check("reset_req",    32'(mem_req),   32'h0);
        check("reset_we",     32'(mem_we),    32'h0);
        check("reset_maddr",  32'(mem_addr),  32'h0);
        check("reset_wdata",  32'(mem_wdata), 32'h0);
        check("reset_cmd",    32'(alu_cmd),   32'h0);

        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start  = 1'b0;
        cur_pc = 8'd0;

        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d_pc", i), 32'(imem_addr), 32'(cur_pc));
            imem_data = vecs[i].instr;
            tick();
            imem_data = 9'h000;
            check($sformatf("v%0d_cmd", i), 32'(alu_cmd), 32'(vecs[i].cmd));
            check($sformatf("v%0d_a", i),   32'(alu_a),   32'(vecs[i].a));
            check($sformatf("v%0d_b", i),   32'(alu_b),   32'(vecs[i].b));
            tick();
            if (vecs[i].is_mem) begin
                check($sformatf("v%0d_req", i),   32'(mem_req),  32'h1);
                check($sformatf("v%0d_we", i),    32'(mem_we),   32'(vecs[i].we));
                check($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].maddr));
                if (vecs[i].we) begin
                    check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwdata));
                end
                for (int k = 0; k < vecs[i].wait_n; k++) begin
                    tick();
                    check($sformatf("v%0d_hold%0d", i, k),
                          32'({mem_req, mem_we, mem_addr, mem_wdata}),
                          32'({1'b1, vecs[i].we, vecs[i].maddr,
                               (vecs[i].we ? vecs[i].mwdata : mem_wdata)}));
                end
                mem_ack   = 1'b1;
                mem_rdata = vecs[i].rdata;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
                check($sformatf("v%0d_req_drop", i), 32'(mem_req), 32'h0);
            end else begin
                check($sformatf("v%0d_noreq", i), 32'(mem_req), 32'h0);
            end
            cur_pc = vecs[i].pc_next;
        end

        // HALT at pc=1 with a start pulse that must be ignored while busy.
        check("halt_pc", 32'(imem_addr), 32'h1);
        imem_data = 9'h1FF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        imem_data = 9'h000;
        check("halt_done",    32'(done),      32'h1);
        check("halt_pc_hold", 32'(imem_addr), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("done_hold",      32'(done),      32'h1);
        check("done_pc_hold",   32'(imem_addr), 32'h1);
        check("done_ack_noreq", 32'(mem_req),   32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done", 32'(done),      32'h0);
        check("restart_pc",   32'(imem_addr), 32'h0);

        // Reset while waiting in MEM, followed by a late ack.
        imem_data = 9'b110_011_011;
        tick();
        imem_data = 9'h000;
        check("rmem_a", 32'(alu_a), 32'hA5);
        tick();
        check("rmem_req",   32'(mem_req),  32'h1);
        check("rmem_maddr", 32'(mem_addr), 32'h4A);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        check("rmem_req_drop", 32'(mem_req),   32'h0);
        check("rmem_pc",       32'(imem_addr), 32'h0);
        check("rmem_maddr0",   32'(mem_addr),  32'h0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        imem_data = 9'b001_011_101;
        check("late_ack_req", 32'(mem_req), 32'h0);
        tick();
        tick();
        check("idle_hold_cmd", 32'(alu_cmd),   32'h0);
        check("idle_hold_pc",  32'(imem_addr), 32'h0);

        // Reset and start together: reset wins, so no fetch/exec follows.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_cmd", 32'(alu_cmd), 32'h0);

        // Start a run; registers must read back as cleared by reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("post_rst_cmd", 32'(alu_cmd), 32'h1);
        check("post_rst_a",   32'(alu_a),   32'h0);
        check("post_rst_b",   32'(alu_b),   32'h0);
        tick();
        check("post_rst_pc",  32'(imem_addr), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
